// File: rtl/mux_pkg.sv
// Shared constants for the round-robin 4-to-1 collector.
// Channel codes double as arbiter indices and as the SEL tag on the output.
package mux_pkg;

  localparam int DATA_W = 2;
  localparam int N_CH   = 4;
  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;

  localparam logic [CODE_W-1:0] CH_W = 2'd0;
  localparam logic [CODE_W-1:0] CH_X = 2'd1;
  localparam logic [CODE_W-1:0] CH_Y = 2'd2;
  localparam logic [CODE_W-1:0] CH_Z = 2'd3;

  // Pointer value after reset: the search starts at pointer+1, so W wins first.
  localparam logic [CODE_W-1:0] PTR_RESET = CH_Z;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage : mux_pkg

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant logic.
// The search begins at (ptr_i + 1) mod 4 and wraps 3 -> 0; the first
// requesting channel found wins. Purely combinational: the caller owns the
// pointer register and decides when it advances.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [N_CH-1:0]   req_i,
  input  logic [CODE_W-1:0] ptr_i,
  input  logic              enable_i,
  output logic [N_CH-1:0]   grant_o,
  output logic [CODE_W-1:0] code_o,
  output logic              any_grant_o
);

  logic              found;
  logic [CODE_W-1:0] idx;

  // Scan the four channels in round-robin order and grant the first requester.
  always_comb begin
    grant_o     = '0;
    code_o      = '0;
    any_grant_o = 1'b0;
    found       = 1'b0;
    idx         = '0;
    if (enable_i) begin
      for (int i = 1; i <= N_CH; i++) begin
        idx = ptr_i + CODE_W'(i);
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          grant_o[idx] = 1'b1;
          code_o       = idx;
        end
      end
      any_grant_o = found;
    end
  end

endmodule : rr_arbiter4

// File: rtl/rr_multiplexer.sv
// Round-robin 4-to-1 collector with a one-beat output register.
//
// Handshake: a channel beat transfers on any cycle where its valid and ready
// are both high; the output beat is consumed on any cycle where out_valid and
// out_ready are both high. Channel valid never depends on ready, and a
// channel holds its data while valid=1 and ready=0. Readies are combinational
// from the valids, the output register state and out_ready.
//
// Optional feature: define RR_MUX_GRANT_CNT_EN to add grant_cnt[7:0], a
// saturating count of accepted channel beats.
module rr_multiplexer
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] W,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [DATA_W-1:0] Z,
  input  logic              w_valid,
  input  logic              x_valid,
  input  logic              y_valid,
  input  logic              z_valid,
  output logic              w_ready,
  output logic              x_ready,
  output logic              y_ready,
  output logic              z_ready,
  output logic [DATA_W-1:0] A,
  output logic [CODE_W-1:0] SEL,
  output logic              out_valid,
  input  logic              out_ready
`ifdef RR_MUX_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt
`endif
);

  // Output register and last-granted pointer.
  logic [DATA_W-1:0] a_q,   a_d;
  logic [CODE_W-1:0] sel_q, sel_d;
  logic              ov_q,  ov_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;

  logic              load_en;
  logic              arb_en;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   grant;
  logic [CODE_W-1:0] grant_code;
  logic              xfer;
  logic [DATA_W-1:0] grant_data;

  // The output slot can take a new beat when empty or being drained now.
  assign load_en = !ov_q || out_ready;

  // Readies are held low while reset is asserted so no beat is offered then.
  assign arb_en = load_en && rst_n;

  assign req = {z_valid, y_valid, x_valid, w_valid};

  rr_arbiter4 u_arb (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .enable_i    (arb_en),
    .grant_o     (grant),
    .code_o      (grant_code),
    .any_grant_o (xfer)
  );

  // A grant is only ever issued to a valid channel, so ready implies transfer.
  assign w_ready = grant[CH_W];
  assign x_ready = grant[CH_X];
  assign y_ready = grant[CH_Y];
  assign z_ready = grant[CH_Z];

  // Select the data of the granted channel.
  always_comb begin
    grant_data = W;
    case (grant_code)
      CH_W:    grant_data = W;
      CH_X:    grant_data = X;
      CH_Y:    grant_data = Y;
      CH_Z:    grant_data = Z;
      default: grant_data = W;
    endcase
  end

  // Next state of the output slot and pointer: load on transfer, else drain.
  always_comb begin
    a_d   = a_q;
    sel_d = sel_q;
    ov_d  = ov_q;
    ptr_d = ptr_q;
    if (xfer) begin
      a_d   = grant_data;
      sel_d = grant_code;
      ov_d  = 1'b1;
      ptr_d = grant_code;
    end else if (out_ready) begin
      // Data and tag keep their last values; only the valid flag drops.
      ov_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      sel_q <= '0;
      ov_q  <= 1'b0;
      ptr_q <= PTR_RESET;
    end else begin
      a_q   <= a_d;
      sel_q <= sel_d;
      ov_q  <= ov_d;
      ptr_q <= ptr_d;
    end
  end

  assign A         = a_q;
  assign SEL       = sel_q;
  assign out_valid = ov_q;

`ifdef RR_MUX_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of accepted channel beats.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule : rr_multiplexer

// File: tb/tb_rr_multiplexer.sv
// Directed bench for rr_multiplexer. Expected output beats {SEL, A} are
// pushed when the stimulus that produces them is driven and popped by a
// monitor when the DUT's output beat is consumed. Define RR_MUX_GRANT_CNT_EN
// to also exercise the grant counter.
module tb_rr_multiplexer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [1:0] W = 2'd0, X = 2'd0, Y = 2'd0, Z = 2'd0;
  logic       w_valid = 1'b0, x_valid = 1'b0, y_valid = 1'b0, z_valid = 1'b0;
  logic       w_ready, x_ready, y_ready, z_ready;
  logic [1:0] A, SEL;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef RR_MUX_GRANT_CNT_EN
  logic [7:0] grant_cnt;
`endif

  logic [3:0] rdy;
  logic [3:0] vld;
  assign rdy = {z_ready, y_ready, x_ready, w_ready};
  assign vld = {z_valid, y_valid, x_valid, w_valid};

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  bit mon_en = 1'b0;

  rr_multiplexer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .W         (W),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .w_valid   (w_valid),
    .x_valid   (x_valid),
    .y_valid   (y_valid),
    .z_valid   (z_valid),
    .w_ready   (w_ready),
    .x_ready   (x_ready),
    .y_ready   (y_ready),
    .z_ready   (z_ready),
    .A         (A),
    .SEL       (SEL),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_MUX_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ---------------- monitor / scoreboard ----------------
  logic [3:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (($countones(rdy) > 1) || ((rdy & vld) !== rdy) ||
          ((out_valid === 1'b1) && (out_ready === 1'b0) && (rdy !== 4'b0))) begin
        bad++;
        $display("FAIL ready_rules rdy=%b valid=%b out_valid=%b out_ready=%b",
                 rdy, vld, out_valid, out_ready);
      end
      if (mon_en && (out_valid === 1'b1) && (out_ready === 1'b1)) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got {SEL,A}=%b expected none", {SEL, A});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({SEL, A} !== mon_exp) begin
            bad++;
            $display("FAIL beat got {SEL,A}=%b expected %b", {SEL, A}, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    w_valid = 1'b0; x_valid = 1'b0; y_valid = 1'b0; z_valid = 1'b0;
    W = 2'd0; X = 2'd0; Y = 2'd0; Z = 2'd0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    drive_idle();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step();
    rst_n = 1'b0;
    out_ready = 1'b1;
    w_valid = 1'b1; x_valid = 1'b1; y_valid = 1'b1; z_valid = 1'b1;
    W = 2'($urandom_range(0, 3)); X = 2'($urandom_range(0, 3));
    Y = 2'($urandom_range(0, 3)); Z = 2'($urandom_range(0, 3));
    #1;
    total++;
    if (rdy !== 4'b0) begin bad++; $display("FAIL reset_ready got %b expected 0000", rdy); end
    repeat (2) begin
      step();
      total++;
      if ({out_valid, A, SEL} !== 5'b0) begin
        bad++;
        $display("FAIL reset_regs got ov=%b A=%b SEL=%b expected 0 00 00", out_valid, A, SEL);
      end
      #1;
      total++;
      if (rdy !== 4'b0) begin bad++; $display("FAIL reset_ready got %b expected 0000", rdy); end
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    Y = 2'b11; y_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (rdy !== 4'b0100) begin bad++; $display("FAIL single_ready got %b expected 0100", rdy); end
    exp_q.push_back({2'b10, 2'b11});
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b1_10_11) begin
      bad++;
      $display("FAIL single_out got ov=%b SEL=%b A=%b expected 1 10 11", out_valid, SEL, A);
    end
    y_valid = 1'b0;
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b0_10_11) begin
      bad++;
      $display("FAIL drain_hold got ov=%b SEL=%b A=%b expected 0 10 11", out_valid, SEL, A);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] dat [4];
    logic [1:0] cc;
    dat = '{2'd0, 2'd1, 2'd1, 2'd3};
    W = dat[0]; X = dat[1]; Y = dat[2]; Z = dat[3];
    w_valid = 1'b1; x_valid = 1'b1; y_valid = 1'b1; z_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cc = 2'(k % 4);
      #1;
      total++;
      if (rdy !== (4'b0001 << cc)) begin
        bad++;
        $display("FAIL rr_ready step=%0d got %b expected %b", k, rdy, 4'b0001 << cc);
      end
      exp_q.push_back({cc, dat[cc]});
      step();
      total++;
      if ({out_valid, SEL, A} !== {1'b1, cc, dat[cc]}) begin
        bad++;
        $display("FAIL rr_out step=%0d got ov=%b SEL=%b A=%b expected 1 %b %b",
                 k, out_valid, SEL, A, cc, dat[cc]);
      end
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    step();
    out_ready = 1'b0;
    X = 2'b10; x_valid = 1'b1;
    #1;
    total++;
    if (rdy !== 4'b0010) begin bad++; $display("FAIL bp_first_ready got %b expected 0010", rdy); end
    exp_q.push_back({2'b01, 2'b10});
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b1_01_10) begin
      bad++;
      $display("FAIL bp_load got ov=%b SEL=%b A=%b expected 1 01 10", out_valid, SEL, A);
    end
    X = 2'b01;
    repeat (3) begin
      #1;
      total++;
      if (rdy !== 4'b0) begin bad++; $display("FAIL bp_ready got %b expected 0000", rdy); end
      step();
      total++;
      if ({out_valid, SEL, A} !== 5'b1_01_10) begin
        bad++;
        $display("FAIL bp_stable got ov=%b SEL=%b A=%b expected 1 01 10", out_valid, SEL, A);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (rdy !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got %b expected 0010", rdy); end
    exp_q.push_back({2'b01, 2'b01});
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b1_01_01) begin
      bad++;
      $display("FAIL bp_release_out got ov=%b SEL=%b A=%b expected 1 01 01", out_valid, SEL, A);
    end
    x_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    Z = 2'b11; z_valid = 1'b1;
    #1;
    total++;
    if (rdy !== 4'b1000) begin bad++; $display("FAIL mid_z_ready got %b expected 1000", rdy); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy !== 4'b0) begin bad++; $display("FAIL mid_rst_ready got %b expected 0000", rdy); end
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b0) begin
      bad++;
      $display("FAIL mid_rst_regs got ov=%b SEL=%b A=%b expected 0 00 00", out_valid, SEL, A);
    end
    rst_n = 1'b1;
    W = 2'b10; w_valid = 1'b1;
    #1;
    total++;
    if (rdy !== 4'b0001) begin bad++; $display("FAIL mid_w_first got %b expected 0001", rdy); end
    exp_q.push_back({2'b00, 2'b10});
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b1_00_10) begin
      bad++;
      $display("FAIL mid_w_out got ov=%b SEL=%b A=%b expected 1 00 10", out_valid, SEL, A);
    end
    w_valid = 1'b0;
    #1;
    total++;
    if (rdy !== 4'b1000) begin bad++; $display("FAIL mid_z_next got %b expected 1000", rdy); end
    exp_q.push_back({2'b11, 2'b11});
    step();
    total++;
    if ({out_valid, SEL, A} !== 5'b1_11_11) begin
      bad++;
      $display("FAIL mid_z_out got ov=%b SEL=%b A=%b expected 1 11 11", out_valid, SEL, A);
    end
    z_valid = 1'b0;
    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
    end
  endtask

`ifdef RR_MUX_GRANT_CNT_EN
  task automatic test_grant_cnt();
    mon_en = 1'b0;
    do_reset();
    total++;
    if (grant_cnt !== 8'd0) begin bad++; $display("FAIL cnt_reset got %0d expected 0", grant_cnt); end
    w_valid = 1'b1; x_valid = 1'b1; y_valid = 1'b1; z_valid = 1'b1;
    out_ready = 1'b1;
    repeat (100) step();
    total++;
    if (grant_cnt !== 8'd100) begin bad++; $display("FAIL cnt_100 got %0d expected 100", grant_cnt); end
    repeat (200) step();
    total++;
    if (grant_cnt !== 8'd255) begin bad++; $display("FAIL cnt_sat got %0d expected 255", grant_cnt); end
    drive_idle();
    step();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    mon_en = 1'b1;
    test_single();
    do_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef RR_MUX_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_multiplexer
